// File: rtl/decode_pipe_fwd.sv
// decode_pipe_fwd: IF/ID register with stall/flush, priority operand forwarding, load-use bubbles and branch compare
module decode_pipe_fwd #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int NUM_FWD = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      in_we,
  input  logic                      in_is_load,
  input  logic                      in_uses_rs1,
  input  logic                      in_uses_rs2,
  input  logic [ADDR_W-1:0]         in_rs1,
  input  logic [ADDR_W-1:0]         in_rs2,
  input  logic [ADDR_W-1:0]         in_rd,
  input  logic [15:0]               in_imm,
  input  logic [DATA_W-1:0]         in_pc4,
  input  logic                      flush,
  input  logic                      ex_stall,
  output logic [ADDR_W-1:0]         rf_raddr1,
  output logic [ADDR_W-1:0]         rf_raddr2,
  input  logic [DATA_W-1:0]         rf_rdata1,
  input  logic [DATA_W-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic                      stall_if,
  output logic                      out_valid,
  output logic                      out_we,
  output logic                      out_is_load,
  output logic [DATA_W-1:0]         out_rs1_val,
  output logic [DATA_W-1:0]         out_rs2_val,
  output logic [ADDR_W-1:0]         out_rd,
  output logic [15:0]               out_imm,
  output logic [DATA_W-1:0]         out_pc4,
  output logic                      br_eq,
  output logic                      br_zero,
  output logic [CNT_W-1:0]          hazard_cnt
);
  logic v, uses1, uses2;
  logic [ADDR_W-1:0] rs1, rs2;
  logic [LOAD_LAT-1:0] slot_v;
  logic [ADDR_W-1:0] slot_rd [LOAD_LAT];
  logic hazard, issue_load;
  function automatic logic [DATA_W-1:0] fwd_sel(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] rf);
    fwd_sel = rf;
    for (int i = NUM_FWD - 1; i >= 0; i--)
      if (fwd_valid[i] && fwd_addr[i*ADDR_W +: ADDR_W] == a) fwd_sel = fwd_data[i*DATA_W +: DATA_W];
    if (a == '0) fwd_sel = '0;
  endfunction
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++)
      hazard = hazard | (slot_v[i] && slot_rd[i] != '0 &&
               ((uses1 && rs1 == slot_rd[i]) || (uses2 && rs2 == slot_rd[i])));
    hazard = hazard & v;
  end
  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;
  assign out_valid = v & ~hazard;
  assign stall_if = hazard | ex_stall;
  assign issue_load = out_valid & out_is_load & out_we & (out_rd != '0);
  assign out_rs1_val = fwd_sel(rs1, rf_rdata1);
  assign out_rs2_val = fwd_sel(rs2, rf_rdata2);
  assign br_eq = out_rs1_val == out_rs2_val;
  assign br_zero = out_rs1_val == '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= 1'b0;
      out_we <= 1'b0;
      out_is_load <= 1'b0;
      uses1 <= 1'b0;
      uses2 <= 1'b0;
      rs1 <= '0;
      rs2 <= '0;
      out_rd <= '0;
      out_imm <= '0;
      out_pc4 <= '0;
      slot_v <= '0;
      for (int i = 0; i < LOAD_LAT; i++) slot_rd[i] <= '0;
      hazard_cnt <= '0;
    end else begin
      if (flush) v <= 1'b0;
      else if (!stall_if) begin
        v <= in_valid;
        out_we <= in_we;
        out_is_load <= in_is_load;
        uses1 <= in_uses_rs1;
        uses2 <= in_uses_rs2;
        rs1 <= in_rs1;
        rs2 <= in_rs2;
        out_rd <= in_rd;
        out_imm <= in_imm;
        out_pc4 <= in_pc4;
      end
      if (!ex_stall) begin
        for (int i = 1; i < LOAD_LAT; i++) begin
          slot_v[i] <= slot_v[i-1];
          slot_rd[i] <= slot_rd[i-1];
        end
        slot_v[0] <= issue_load;
        slot_rd[0] <= out_rd;
      end
      if (hazard && !ex_stall && !(&hazard_cnt)) hazard_cnt <= hazard_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_decode_pipe_fwd.sv
// tb_decode_pipe_fwd: directed scoreboard bench driving LOAD_LAT=1 and LOAD_LAT=3 instances in lockstep
module tb_decode_pipe_fwd;
  logic clk = 1'b0;
  logic reset, in_valid, in_we, in_is_load, in_uses_rs1, in_uses_rs2, flush, ex_stall;
  logic [5:0] in_rs1, in_rs2, in_rd;
  logic [15:0] in_imm;
  logic [31:0] in_pc4, rf_rdata1, rf_rdata2;
  logic [2:0] fwd_valid;
  logic [17:0] fwd_addr;
  logic [95:0] fwd_data;
  logic [5:0] a_raddr1, a_raddr2, a_rd, b_raddr1, b_raddr2, b_rd;
  logic a_stall, a_valid, a_we, a_ld, a_eq, a_zero, b_stall, b_valid, b_we, b_ld, b_eq, b_zero;
  logic [31:0] a_rs1v, a_rs2v, a_pc4, b_rs1v, b_rs2v, b_pc4;
  logic [15:0] a_imm, b_imm, a_cnt;
  logic [1:0] b_cnt;
  logic [37:0] q1[$], q3[$];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  decode_pipe_fwd #(.LOAD_LAT(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_we(in_we), .in_is_load(in_is_load),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_imm(in_imm), .in_pc4(in_pc4), .flush(flush), .ex_stall(ex_stall),
    .rf_raddr1(a_raddr1), .rf_raddr2(a_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .stall_if(a_stall),
    .out_valid(a_valid), .out_we(a_we), .out_is_load(a_ld), .out_rs1_val(a_rs1v),
    .out_rs2_val(a_rs2v), .out_rd(a_rd), .out_imm(a_imm), .out_pc4(a_pc4), .br_eq(a_eq),
    .br_zero(a_zero), .hazard_cnt(a_cnt));
  decode_pipe_fwd #(.LOAD_LAT(3), .CNT_W(2)) u3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_we(in_we), .in_is_load(in_is_load),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_imm(in_imm), .in_pc4(in_pc4), .flush(flush), .ex_stall(ex_stall),
    .rf_raddr1(b_raddr1), .rf_raddr2(b_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .stall_if(b_stall),
    .out_valid(b_valid), .out_we(b_we), .out_is_load(b_ld), .out_rs1_val(b_rs1v),
    .out_rs2_val(b_rs2v), .out_rd(b_rd), .out_imm(b_imm), .out_pc4(b_pc4), .br_eq(b_eq),
    .br_zero(b_zero), .hazard_cnt(b_cnt));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    @(negedge clk);
  endtask
  task automatic instr(input logic ld, we, u1_, u2_, input logic [5:0] r1, r2, rd,
                       input logic [15:0] imm, input logic [31:0] pc);
    in_valid = 1'b1; in_is_load = ld; in_we = we; in_uses_rs1 = u1_; in_uses_rs2 = u2_;
    in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_imm = imm; in_pc4 = pc;
    q1.push_back({pc, rd});
    q3.push_back({pc, rd});
  endtask
  always @(negedge clk) begin
    if (!reset && !ex_stall && a_valid) begin
      checks++;
      assert (q1.size() != 0) else begin
        failures++;
        $error("FAIL issue1_extra observed=%0h expected=none", a_pc4);
      end
      if (q1.size() != 0) chk("issue1", {a_pc4, a_rd}, q1.pop_front());
    end
    if (!reset && !ex_stall && b_valid) begin
      checks++;
      assert (q3.size() != 0) else begin
        failures++;
        $error("FAIL issue3_extra observed=%0h expected=none", b_pc4);
      end
      if (q3.size() != 0) chk("issue3", {b_pc4, b_rd}, q3.pop_front());
    end
  end
  initial begin
    reset = 1'b1; flush = 1'b0; ex_stall = 1'b0;
    in_valid = 1'b0; in_we = 1'b0; in_is_load = 1'b0; in_uses_rs1 = 1'b0; in_uses_rs2 = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0; in_pc4 = '0;
    rf_rdata1 = 32'hDEAD; rf_rdata2 = 32'hBEEF;
    fwd_valid = '0; fwd_addr = '0; fwd_data = '0;
    nxt(); nxt(); settle();
    chk("rst_valid", a_valid, 0);
    chk("rst_stall", a_stall, 0);
    chk("rst_rd", a_rd, 0);
    chk("rst_imm", a_imm, 0);
    chk("rst_pc4", a_pc4, 0);
    chk("rst_we_ld", {a_we, a_ld}, 0);
    chk("rst_br", {a_eq, a_zero}, 2'b11);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_valid3", {b_valid, b_cnt}, 0);
    ex_stall = 1'b1; #1;
    chk("rst_stall_ex", a_stall, 1);
    ex_stall = 1'b0;
    // capture then hold under ex_stall
    nxt(); reset = 1'b0;
    instr(0, 1, 1, 1, 5, 6, 2, 16'h1234, 32'h100);
    nxt(); ex_stall = 1'b1;
    instr(0, 1, 1, 1, 5, 6, 3, 16'h5678, 32'h200);
    for (int k = 0; k < 3; k++) begin
      if (k != 0) nxt();
      settle();
      chk("hold_pc4", a_pc4, 32'h100);
      chk("hold_imm", a_imm, 16'h1234);
      chk("hold_stall", a_stall, 1);
    end
    nxt(); ex_stall = 1'b0; settle();
    chk("release_pc4", a_pc4, 32'h100);
    nxt(); in_valid = 1'b0; settle();
    chk("cap_pc4", a_pc4, 32'h200);
    chk("cap_imm", a_imm, 16'h5678);
    nxt(); settle();
    // load-use on both latencies
    nxt(); instr(1, 1, 0, 0, 0, 0, 7, 0, 32'h10); settle();
    nxt(); instr(0, 1, 0, 1, 1, 7, 3, 0, 32'h14);
    fwd_valid = 3'b001; fwd_addr = {12'd0, 6'd7}; fwd_data = {64'd0, 32'h77}; rf_rdata2 = 32'h11;
    settle();
    chk("lu_load_held", a_ld, 1);
    nxt(); in_valid = 1'b0; settle();
    chk("lu1_bubble", {a_valid, a_stall}, 2'b01);
    chk("lu1_cnt0", a_cnt, 0);
    chk("lu3_bubble1", b_valid, 0);
    nxt(); settle();
    chk("lu1_issue", a_valid, 1);
    chk("lu1_fwd", a_rs2v, 32'h77);
    chk("lu1_cnt1", a_cnt, 1);
    chk("lu3_bubble2", {b_valid, b_stall, b_cnt}, 4'b0101);
    nxt(); settle();
    chk("lu3_bubble3", {b_valid, b_cnt}, 3'b010);
    nxt(); settle();
    chk("lu3_issue", {b_valid, b_stall}, 2'b10);
    chk("lu3_fwd", b_rs2v, 32'h77);
    chk("lu3_cnt3", b_cnt, 3);
    nxt(); fwd_valid = '0; settle();
    // independent follower of a load
    nxt(); instr(1, 1, 0, 0, 0, 0, 7, 0, 32'h20); settle();
    nxt(); instr(0, 1, 1, 1, 8, 9, 4, 0, 32'h24); settle();
    nxt(); in_valid = 1'b0; settle();
    chk("indep1", {a_valid, a_stall}, 2'b10);
    chk("indep3", {b_valid, b_stall}, 2'b10);
    repeat (3) nxt();
    // flush while a dependent instruction is stalled
    instr(1, 1, 0, 0, 0, 0, 7, 0, 32'h40); settle();
    nxt(); instr(0, 1, 1, 0, 7, 0, 5, 0, 32'h44); settle();
    nxt(); in_valid = 1'b0; settle();
    chk("fl_haz", {a_valid, a_stall, b_valid, b_stall}, 4'b0101);
    flush = 1'b1;
    void'(q1.pop_back());
    void'(q3.pop_back());
    nxt(); flush = 1'b0;
    instr(0, 1, 1, 1, 8, 9, 6, 0, 32'h48);
    settle();
    chk("fl_cleared", {a_valid, a_stall, b_valid, b_stall}, 4'b0000);
    chk("fl_cnt1", a_cnt, 2);
    chk("fl_cnt3_sat", b_cnt, 3);
    nxt(); in_valid = 1'b0; settle();
    chk("fl_next", {a_valid, b_valid}, 2'b11);
    chk("fl_next_pc", a_pc4, 32'h48);
    // forwarding priority
    nxt(); instr(0, 0, 1, 1, 5, 6, 0, 0, 32'h60); settle();
    nxt(); in_valid = 1'b0;
    fwd_valid = 3'b110; fwd_addr = {6'd5, 6'd5, 6'd0}; fwd_data = {32'hBB, 32'hAA, 32'h0};
    rf_rdata1 = 32'hCC;
    settle();
    chk("fwd_prio", a_rs1v, 32'hAA);
    chk("fwd_raddr", a_raddr1, 5);
    #1 fwd_valid = '0;
    #1 chk("fwd_rf", a_rs1v, 32'hCC);
    nxt(); instr(0, 0, 1, 1, 0, 6, 0, 0, 32'h64);
    fwd_valid = 3'b111; fwd_addr = '0; fwd_data = {32'd3, 32'd2, 32'd1};
    settle();
    nxt(); in_valid = 1'b0; settle();
    chk("fwd_zero", a_rs1v, 0);
    // full-width branch compare
    nxt(); instr(0, 0, 1, 1, 5, 6, 0, 0, 32'h68); fwd_valid = '0; settle();
    nxt(); in_valid = 1'b0;
    fwd_valid = 3'b001; fwd_addr = {12'd0, 6'd5}; fwd_data = {64'd0, 32'h80000000};
    rf_rdata1 = 32'h123; rf_rdata2 = 32'h0;
    settle();
    chk("br_rs1", a_rs1v, 32'h80000000);
    chk("br_msb", {a_eq, a_zero}, 2'b00);
    #1 fwd_valid = '0; rf_rdata1 = 32'hFFFF0001; rf_rdata2 = 32'hFFFF0001;
    #1 chk("br_eq_full", {a_eq, a_zero}, 2'b10);
    repeat (4) nxt();
    settle();
    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
